// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//
// Branch history table predictor with optional gshare indexing.
// A table of 2^INDEX_BITS saturating counters is indexed by PC bits XORed
// with a speculative global history register (ghr). Each predicted branch
// pushes {idx, ghr snapshot, prediction} into a small FIFO. When the branch
// resolves in MEM, the head entry trains the counter it was predicted from.
// On a misprediction, the FIFO is flushed and ghr is rebuilt from the
// snapshot.
//
// Parameters:
//   INDEX_BITS : log2 of table entries; index = in_addr[INDEX_BITS+1:2]
//   CTR_BITS   : counter width, prediction = counter MSB
//   HIST_BITS  : global history length (0 = pure bimodal, <= INDEX_BITS)
//   DEPTH      : pending-branch FIFO depth (power of 2, >= 2)
//
// Ports:
//   clk                    : rising-edge clock
//   rst_n                  : asynchronous active-low reset
//   branch_decode_sig      : conditional branch in decode this cycle
//   branch_mem_sig         : oldest in-flight branch resolves this cycle
//   actual_branch_decision : resolved outcome (1 = taken)
//   in_addr                : PC of the decoding branch
//   offset                 : sign-extended branch immediate
//   branch_addr            : in_addr + offset (combinational)
//   prediction             : predicted direction (combinational)
//   mispredict             : resolved outcome differs from stored prediction
//   pending_full           : FIFO holds DEPTH entries (registered)
//
// Handshake: branch_decode_sig and branch_mem_sig are single-cycle
// qualifiers without back-pressure. A decode is accepted when the FIFO is
// not full, or when a pop frees a slot in the same cycle, and no mispredict
// is flushing. pending_full tells the core to stop issuing branches.
// A MEM pulse while the FIFO is empty is ignored.
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_decode_sig,
  input  logic        branch_mem_sig,
  input  logic        actual_branch_decision,
  input  logic [31:0] in_addr,
  input  logic [31:0] offset,
  output logic [31:0] branch_addr,
  output logic        prediction,
  output logic        mispredict,
  output logic        pending_full
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // ghr keeps one bit of storage even in bimodal mode, held at zero there.
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

  typedef struct packed {
    logic [INDEX_BITS-1:0] idx;
    logic [GW-1:0]         ghr;
    logic                  pred;
  } pend_t;

  logic [CTR_BITS-1:0]   bht_q [ENTRIES];
  logic [GW-1:0]         ghr_q;
  pend_t                 fifo_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  full_q;

  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] idx;
  pend_t                 head;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic [CTR_BITS-1:0]   head_ctr;
  logic [CTR_BITS-1:0]   ctr_next;

  // Shift a new outcome into the history; always zero in bimodal mode.
  function automatic logic [GW-1:0] shift_hist(input logic [GW-1:0] h, input logic b);
    if (HIST_BITS == 0) begin
      return '0;
    end
    return GW'({h, b});
  endfunction

  // PC bits outside the index field do not steer the table.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_addr[31:INDEX_BITS+2], in_addr[1:0]};

  assign ghr_ext     = INDEX_BITS'(ghr_q);
  assign idx         = in_addr[INDEX_BITS+1:2] ^ ghr_ext;
  assign prediction  = bht_q[idx][CTR_BITS-1];
  assign branch_addr = in_addr + offset;

  assign head       = fifo_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign pop        = branch_mem_sig & ~empty;
  assign mispredict = pop & (actual_branch_decision != head.pred);
  // A mispredict squashes the younger branch decoding in the same cycle.
  assign push       = branch_decode_sig & (~full_q | pop) & ~mispredict;

  assign pending_full = full_q;

  // Saturating update of the counter that produced the head prediction.
  assign head_ctr = bht_q[head.idx];
  always_comb begin
    ctr_next = head_ctr;
    if (actual_branch_decision) begin
      if (head_ctr != '1) ctr_next = head_ctr + CTR_BITS'(1);
    end else begin
      if (head_ctr != '0) ctr_next = head_ctr - CTR_BITS'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (mispredict) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter table. A same-cycle read of the updated entry sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= CTR_RESET;
      end
    end else if (pop) begin
      bht_q[head.idx] <= ctr_next;
    end
  end

  // FIFO payload needs no reset; occupancy and pointers say what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{idx: idx, ghr: ghr_q, pred: prediction};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ghr_q    <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (mispredict) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        // Repair history: snapshot taken at decode plus the real outcome.
        ghr_q    <= shift_hist(head.ghr, actual_branch_decision);
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
          ghr_q    <= shift_hist(ghr_q, prediction);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Two predictors share one set of inputs. One uses gshare with the default
// parameters. The other is bimodal with HIST_BITS = 0.
// Each cycle, both are compared with a queue-based model of the predictor
// rules. Hand-derived tables and sequences cover the specific corner cases.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst_n;
  logic        dec;
  logic        mem;
  logic        act;
  logic [31:0] addr;
  logic [31:0] off;

  logic [31:0] ba_g, ba_b;
  logic        pred_g, pred_b, mis_g, mis_b, full_g, full_b;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_bht dut (
    .clk(clk), .rst_n(rst_n), .branch_decode_sig(dec), .branch_mem_sig(mem),
    .actual_branch_decision(act), .in_addr(addr), .offset(off),
    .branch_addr(ba_g), .prediction(pred_g), .mispredict(mis_g), .pending_full(full_g)
  );

  branch_predictor_bht #(.HIST_BITS(0)) dut_bm (
    .clk(clk), .rst_n(rst_n), .branch_decode_sig(dec), .branch_mem_sig(mem),
    .actual_branch_decision(act), .in_addr(addr), .offset(off),
    .branch_addr(ba_b), .prediction(pred_b), .mispredict(mis_b), .pending_full(full_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Instance 0 = gshare (2 history bits), instance 1 = bimodal.
  typedef struct {
    int idx;
    int ghr;
    bit pred;
  } pend_t;

  int    mctr [2][16];
  int    mghr [2];
  pend_t mq   [2][$];
  int    hmask [2] = '{3, 0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int e = 0; e < 16; e++) mctr[i][e] = 1;
      mghr[i] = 0;
      mq[i].delete();
    end
  endtask

  function automatic int m_idx(int i);
    return int'((addr >> 2) & 32'hF) ^ mghr[i];
  endfunction

  function automatic bit m_pred(int i);
    return (mctr[i][m_idx(i)] >= 2);
  endfunction

  function automatic bit m_mis(int i);
    if (!mem || mq[i].size() == 0) return 1'b0;
    return (act != mq[i][0].pred);
  endfunction

  function automatic bit m_full(int i);
    return (mq[i].size() == 4);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int    idx;
      bit    p;
      int    sz;
      bit    popping;
      bit    mis;
      pend_t h;
      idx     = m_idx(i);
      p       = m_pred(i);
      sz      = mq[i].size();
      popping = mem && (sz > 0);
      mis     = m_mis(i);
      h       = '{0, 0, 1'b0};
      if (popping) begin
        int c;
        h = mq[i][0];
        c = mctr[i][h.idx];
        if (act) c = (c < 3) ? c + 1 : 3;
        else     c = (c > 0) ? c - 1 : 0;
        mctr[i][h.idx] = c;
        void'(mq[i].pop_front());
      end
      if (mis) begin
        mq[i].delete();
        mghr[i] = ((h.ghr << 1) | int'(act)) & hmask[i];
      end else if (dec && (sz < 4 || popping)) begin
        mq[i].push_back('{idx, mghr[i], p});
        mghr[i] = ((mghr[i] << 1) | int'(p)) & hmask[i];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("g_pred",  {31'b0, pred_g}, {31'b0, m_pred(0)});
    chk("g_mis",   {31'b0, mis_g},  {31'b0, m_mis(0)});
    chk("g_full",  {31'b0, full_g}, {31'b0, m_full(0)});
    chk("g_baddr", ba_g, addr + off);
    chk("b_pred",  {31'b0, pred_b}, {31'b0, m_pred(1)});
    chk("b_mis",   {31'b0, mis_b},  {31'b0, m_mis(1)});
    chk("b_full",  {31'b0, full_b}, {31'b0, m_full(1)});
    chk("b_baddr", ba_b, addr + off);
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle_and_check();
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic d, input logic m, input logic a, input logic [31:0] pc);
    dec  = d;
    mem  = m;
    act  = a;
    addr = pc;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        dec;
    logic        mem;
    logic        act;
    logic [31:0] addr;
    logic        exp_pred;
    logic        exp_mis;
  } vec_t;

  function automatic vec_t mk(logic d, logic m, logic a, logic [31:0] pc, logic ep, logic em);
    vec_t v;
    v.dec = d; v.mem = m; v.act = a; v.addr = pc; v.exp_pred = ep; v.exp_mis = em;
    return v;
  endfunction

  vec_t vt [18];

  initial begin
    logic p5;

    // Bimodal training at 0x84 (index 1), then decay and the 0x88 neighbour.
    vt[0]  = mk(1, 0, 0, 32'h84, 0, 0);
    vt[1]  = mk(0, 1, 1, 32'h84, 0, 1);  // 01 -> 10
    vt[2]  = mk(1, 0, 0, 32'h84, 1, 0);
    vt[3]  = mk(0, 1, 1, 32'h84, 1, 0);  // 10 -> 11
    vt[4]  = mk(1, 0, 0, 32'h84, 1, 0);
    vt[5]  = mk(0, 1, 1, 32'h84, 1, 0);  // holds at 11
    vt[6]  = mk(1, 0, 0, 32'h84, 1, 0);
    vt[7]  = mk(0, 1, 0, 32'h84, 1, 1);  // 11 -> 10
    vt[8]  = mk(1, 0, 0, 32'h84, 1, 0);
    vt[9]  = mk(0, 1, 0, 32'h84, 1, 1);  // 10 -> 01
    vt[10] = mk(1, 0, 0, 32'h84, 0, 0);
    vt[11] = mk(0, 1, 0, 32'h84, 0, 0);  // 01 -> 00
    vt[12] = mk(1, 0, 0, 32'h84, 0, 0);
    vt[13] = mk(0, 1, 0, 32'h84, 0, 0);  // holds at 00
    vt[14] = mk(1, 0, 0, 32'h88, 0, 0);  // 0x88 still 01
    vt[15] = mk(0, 1, 1, 32'h88, 0, 1);  // 01 -> 10
    vt[16] = mk(0, 0, 0, 32'h88, 1, 0);
    vt[17] = mk(0, 0, 0, 32'h84, 0, 0);  // 0x84 did not wrap

    // Outputs while reset is held.
    rst_n = 1'b0;
    drive(1, 1, 1, 32'h84);
    off = 32'h10;
    model_reset();
    #1;
    chk("rst_pred_g", {31'b0, pred_g}, 32'd0);
    chk("rst_pred_b", {31'b0, pred_b}, 32'd0);
    chk("rst_mis_g",  {31'b0, mis_g},  32'd0);
    chk("rst_full_g", {31'b0, full_g}, 32'd0);
    chk("rst_baddr",  ba_g, 32'h94);
    off = 32'hFFFF_FFFC;
    #1;
    chk("rst_baddr_neg", ba_g, 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    off = 32'h0;

    // Table-driven bimodal sequence.
    for (int k = 0; k < 18; k++) begin
      drive(vt[k].dec, vt[k].mem, vt[k].act, vt[k].addr);
      settle_and_check();
      chk($sformatf("tbl%0d_pred", k), {31'b0, pred_b}, {31'b0, vt[k].exp_pred});
      chk($sformatf("tbl%0d_mis", k),  {31'b0, mis_b},  {31'b0, vt[k].exp_mis});
      tick();
    end

    // gshare history repair on misprediction with a squashed decode.
    do_reset();
    drive(1, 0, 0, 32'h84);
    settle_and_check();
    chk("gs_x_pred", {31'b0, pred_g}, 32'd0);
    tick();
    drive(0, 1, 1, 32'h84);                // ghr becomes 01
    settle_and_check();
    chk("gs_x_mis", {31'b0, mis_g}, 32'd1);
    tick();
    drive(1, 0, 0, 32'h88);                // idx 3, snapshot 01, pred 0, ghr -> 10
    settle_and_check();
    chk("gs_a_pred", {31'b0, pred_g}, 32'd0);
    tick();
    drive(1, 1, 1, 32'h90);                // mispredict, decode squashed, ghr -> 11
    settle_and_check();
    chk("gs_a_mis", {31'b0, mis_g}, 32'd1);
    tick();
    drive(0, 1, 1, 32'h88);                // empty FIFO: ignored; idx 2^3 = 1 -> 10
    settle_and_check();
    chk("gs_empty_mis", {31'b0, mis_g}, 32'd0);
    chk("gs_empty_full", {31'b0, full_g}, 32'd0);
    chk("gs_ghr11_pred", {31'b0, pred_g}, 32'd1);
    tick();

    // Fill to full, overflow decode, drain with correct resolutions.
    do_reset();
    p5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 32'h84 + 32'(4 * k));
      settle_and_check();
      if (k == 4) begin
        p5 = m_pred(0);
        chk("full_after4", {31'b0, full_g}, 32'd1);
      end
      tick();
    end
    drive(0, 0, 0, 32'h84);
    settle_and_check();
    chk("full_after5", {31'b0, full_g}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, (mq[0].size() > 0) ? mq[0][0].pred : 1'b0, 32'h84);
      settle_and_check();
      chk($sformatf("drain%0d_mis", k), {31'b0, mis_g}, 32'd0);
      tick();
    end
    drive(0, 1, ~p5, 32'h84);
    settle_and_check();
    chk("drained_mis", {31'b0, mis_g}, 32'd0);
    chk("drained_full", {31'b0, full_g}, 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
            $urandom);
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      settle_and_check();
      tick();
    end
    off = 32'h0;

    // Asynchronous reset with trained counters and entries pending.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 32'h84);
      settle_and_check();
      tick();
      drive(0, 1, 1, 32'h84);
      settle_and_check();
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 32'h84);
      settle_and_check();
      tick();
    end
    drive(0, 1, 0, 32'h84);
    settle_and_check();
    chk("pre_rst_pred_b", {31'b0, pred_b}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_pred_b", {31'b0, pred_b}, 32'd0);
    chk("async_pred_g", {31'b0, pred_g}, 32'd0);
    chk("async_mis_b",  {31'b0, mis_b},  32'd0);
    chk("async_mis_g",  {31'b0, mis_g},  32'd0);
    chk("async_full_b", {31'b0, full_b}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 1, 32'h84);
    settle_and_check();
    chk("post_rst_pred_b", {31'b0, pred_b}, 32'd0);
    chk("post_rst_mis_b",  {31'b0, mis_b},  32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history table (BHT) predictor for the pipelined RV32 core. It is the successor to the single-counter `branch_predictor` and replaces it in the fetch/decode path. Each branch gets a saturating counter selected by PC bits, optionally XORed with a speculative global history (gshare). The index and history of each in-flight branch are carried in a small FIFO, so the table is updated at the correct entry when the branch resolves in MEM, and history is repaired on a misprediction.

## Interface
Parameters:
- INDEX_BITS, 4: table has 2^INDEX_BITS entries, indexed by in_addr[INDEX_BITS+1:2].
- CTR_BITS, 2: counter width (≥1). Prediction is the counter MSB.
- HIST_BITS, 2: global history length. 0 gives pure bimodal. Must satisfy HIST_BITS ≤ INDEX_BITS.
- DEPTH, 4: pending-branch FIFO depth (power of 2, ≥2).

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- branch_decode_sig  in  1  a conditional branch is in decode this cycle.
- branch_mem_sig  in  1  the oldest in-flight branch resolves in MEM this cycle.
- actual_branch_decision  in  1  resolved outcome (1 = taken). Valid with branch_mem_sig.
- in_addr  in  32  PC of the decoding branch.
- offset  in  32  branch immediate, sign-extended.
- branch_addr  out  32  in_addr + offset, modulo 2^32, combinational.
- prediction  out  1  predicted direction for the decoding branch, combinational.
- mispredict  out  1  resolved outcome ≠ stored prediction, combinational, qualified by branch_mem_sig and FIFO non-empty.
- pending_full  out  1  FIFO holds DEPTH entries.

## Operation
- idx = in_addr[INDEX_BITS+1:2] XOR zero-extended ghr (ghr = HIST_BITS-bit speculative history; absent if 0).
- prediction = table[idx][CTR_BITS-1]. It is driven regardless of branch_decode_sig; consumers qualify it.
- Decode push (branch_decode_sig, FIFO not full or popping this cycle, no flush):
  - enqueue {idx, ghr, prediction};
  - ghr ← {ghr[HIST_BITS-2:0], prediction}.
- Decode while full and not popping: nothing is enqueued, ghr is unchanged, prediction is still driven. Overflow is a pipeline contract violation; the core guarantees ≤ DEPTH branches in flight.
- MEM pop (branch_mem_sig, FIFO non-empty):
  - dequeue the head entry;
  - table[head.idx] saturating-increments if taken, saturating-decrements if not. The counter holds at all-ones or zero.
- MEM with empty FIFO: ignored. No table change; mispredict = 0.
- Misprediction (pop with actual ≠ head.pred):
  - the FIFO is flushed to empty after the pop;
  - any same-cycle decode push is discarded, because that branch is younger and squashed;
  - ghr ← {head.ghr[HIST_BITS-2:0], actual}.
- Correct prediction: ghr is not touched by the pop. It was already shifted speculatively at decode.
- Simultaneous push and pop (no mispredict): both occur, occupancy is unchanged, and a push is allowed even when full.
- Same-index read and update in one cycle: the read returns the pre-update value.

## Timing
- On reset, every counter is set to weakly-not-taken, 2^(CTR_BITS-1)−1 (01 for 2 bits); CTR_BITS=1 resets to 0.
- Reset also sets ghr = 0 and empties the FIFO.
- Output values in reset (in_addr, offset arbitrary):
  - prediction = 0;
  - mispredict = 0;
  - pending_full = 0;
  - branch_addr = in_addr + offset.
- Reset is asynchronous: asserting rst_n mid-operation clears state immediately, independent of clk. Deassertion takes effect at the next rising edge.
- prediction, branch_addr and mispredict are zero-latency combinational outputs.
- Table, ghr and FIFO update on the rising edge of the cycle where they are sampled. A counter change is visible to prediction in the following cycle.
- pending_full is registered state derived from the occupancy count. The count is 0..DEPTH and needs clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

## Test plan
1. Reset, then in_addr=0x84, offset=0x10 → prediction=0, mispredict=0, pending_full=0, branch_addr=0x94. With offset=0xFFFFFFFC → branch_addr=0x80.
2. HIST_BITS=0, addr 0x84: decode then mem taken, three times. The counter goes 01→10→11→11; prediction reads 0,1,1. mispredict=1 on the first resolution only.
3. HIST_BITS=0, from counter 11 at 0x84: three not-taken resolutions. The counter goes 10→01→00, and a fourth resolution holds at 00. Entry 0x88 stays at 01 throughout.
4. Five decodes with no mem → pending_full=1 after the 4th; the 5th is not queued. Then four correct resolutions empty the FIFO, and a further mem pulse leaves all counters unchanged with mispredict=0.
5. Default parameters with ghr=2'b10, where the head entry has pred=0 and ghr snapshot 2'b01: mem taken plus a simultaneous decode → mispredict=1, FIFO empty next cycle, ghr=2'b11, decode not enqueued.
6. Drop rst_n mid-sequence, between clock edges, with 3 entries pending and counters trained → outputs go to reset values immediately; after release, addr 0x84 predicts 0 and the FIFO is empty.
